// File: rtl/riscv_types.sv
// Shared RISC-V opcode constants, encoder request kinds and immediate range helpers.
package riscv_types;

  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_jump  = 7'b1101111;
  localparam logic [6:0] op_lui   = 7'b0110111;

  typedef enum logic [2:0] {
    ENC_I  = 3'd0,
    ENC_S  = 3'd1,
    ENC_B  = 3'd2,
    ENC_J  = 3'd3,
    ENC_LI = 3'd4
  } enc_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } enc_state_t;

  // True when imm can be carried by the immediate field of the given format.
  function automatic logic imm_in_range(input enc_kind_t kind, input logic [31:0] imm);
    logic signed [31:0] v;
    logic               ok;
    v = $signed(imm);
    case (kind)
      ENC_I, ENC_S: ok = (v >= -32'sd2048) && (v <= 32'sd2047);
      ENC_B:        ok = (v >= -32'sd4096) && (v <= 32'sd4094) && !imm[0];
      ENC_J:        ok = (v >= -32'sd1048576) && (v <= 32'sd1048574) && !imm[0];
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer for the I, S, B and J instruction formats.
module instr_pack
  import riscv_types::*;
#(
  parameter int WIDTH = 32
) (
  input  enc_kind_t        kind,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] word
);

  always_comb begin
    word = '0;
    case (kind)
      ENC_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      ENC_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      ENC_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      ENC_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Registered instruction encoder: packs one request per accept, expanding LI into
// one or two words, with valid/ready handshakes on both sides.
module instr_encoder
  import riscv_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  enc_kind_t        req_kind,
  input  logic [6:0]       req_opcode,
  input  logic [2:0]       req_funct3,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [WIDTH-1:0] req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic             out_last,
  output logic             out_err
);

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_instr_q, out_instr_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic             out_last_q, out_last_d;
  logic             out_err_q, out_err_d;

  logic             accept, out_hs;
  logic             in_range, is_li, li_short, li_lo_zero;
  logic [19:0]      li_hi;
  logic [WIDTH-1:0] lui_word, packed_word;
  enc_kind_t        pack_kind;
  logic [6:0]       pack_opcode;
  logic [2:0]       pack_funct3;
  logic [4:0]       pack_rs1;

  // LI reuses the I-format packer as ADDI; rs1 is x0 for the short form, rd after a LUI.
  assign is_li       = (req_kind == ENC_LI);
  assign li_short    = imm_in_range(ENC_I, req_imm);
  assign li_lo_zero  = (req_imm[11:0] == 12'd0);
  assign li_hi       = req_imm[31:12] + {19'd0, req_imm[11]};
  assign lui_word    = {li_hi, req_rd, op_lui};
  assign in_range    = imm_in_range(req_kind, req_imm);
  assign pack_kind   = is_li ? ENC_I : req_kind;
  assign pack_opcode = is_li ? op_imm : req_opcode;
  assign pack_funct3 = is_li ? 3'b000 : req_funct3;
  assign pack_rs1    = is_li ? (li_short ? 5'd0 : req_rd) : req_rs1;

  instr_pack #(.WIDTH(WIDTH)) u_pack (
    .kind   (pack_kind),
    .opcode (pack_opcode),
    .funct3 (pack_funct3),
    .rd     (req_rd),
    .rs1    (pack_rs1),
    .rs2    (req_rs2),
    .imm    (req_imm),
    .word   (packed_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_EMIT1;
      ST_EMIT1: if (out_hs) state_d = !out_last_q ? ST_EMIT2 : (accept ? ST_EMIT1 : ST_IDLE);
      ST_EMIT2: if (out_hs) state_d = accept ? ST_EMIT1 : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q != ST_IDLE);
    req_ready = (state_q == ST_IDLE) || (out_valid && out_ready && out_last_q);
  end

  assign accept = req_valid && req_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    second_d    = second_q;
    if (accept) begin
      second_d   = '0;
      out_err_d  = 1'b0;
      out_last_d = 1'b1;
      if (!in_range) begin
        out_instr_d = '0;
        out_err_d   = 1'b1;
      end else if (is_li && !li_short) begin
        out_instr_d = lui_word;
        if (!li_lo_zero) begin
          out_last_d = 1'b0;
          second_d   = packed_word;
        end
      end else begin
        out_instr_d = packed_word;
      end
    end else if (out_hs) begin
      // Either advance to the pending ADDI or return to the idle values.
      out_instr_d = out_last_q ? '0 : second_q;
      out_last_d  = !out_last_q;
      out_err_d   = 1'b0;
      second_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      second_q    <= '0;
    end else begin
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      second_q    <= second_d;
    end
  end

  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic
// against an arithmetic reference model of the encoding rules.
module tb_instr_encoder;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  enc_kind_t   req_kind = ENC_I;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  instr_encoder #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .out_err    (out_err)
  );

  function automatic void push_beat(input logic [31:0] w, input logic l, input logic e);
    beat_t b;
    b.instr = w;
    b.last  = l;
    b.err   = e;
    exp_q.push_back(b);
  endfunction

  // Reference model: plain integer arithmetic on the format definitions.
  function automatic void model(input enc_kind_t kind, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
    longint v, u, o, f, d, s1, s2, lo_s, hi;
    v  = longint'($signed(imm));
    u  = longint'(imm);
    o  = longint'(op);
    f  = longint'(f3);
    d  = longint'(rd);
    s1 = longint'(rs1);
    s2 = longint'(rs2);
    case (kind)
      ENC_I:
        if (v < -2048 || v > 2047) push_beat(32'd0, 1'b1, 1'b1);
        else push_beat(32'(((u & 'hFFF) << 20) | (s1 << 15) | (f << 12) | (d << 7) | o), 1'b1, 1'b0);
      ENC_S:
        if (v < -2048 || v > 2047) push_beat(32'd0, 1'b1, 1'b1);
        else push_beat(32'((((u >> 5) & 'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f << 12)
                           | ((u & 'h1F) << 7) | o), 1'b1, 1'b0);
      ENC_B:
        if (v < -4096 || v > 4094 || (u % 2) != 0) push_beat(32'd0, 1'b1, 1'b1);
        else push_beat(32'((((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (s2 << 20)
                           | (s1 << 15) | (f << 12) | (((u >> 1) & 'hF) << 8)
                           | (((u >> 11) & 1) << 7) | o), 1'b1, 1'b0);
      ENC_J:
        if (v < -1048576 || v > 1048574 || (u % 2) != 0) push_beat(32'd0, 1'b1, 1'b1);
        else push_beat(32'((((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
                           | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12)
                           | (d << 7) | o), 1'b1, 1'b0);
      default: begin
        lo_s = u % 4096;
        if (lo_s >= 2048) lo_s = lo_s - 4096;
        hi = ((v - lo_s) / 4096) & 'hFFFFF;
        if (v >= -2048 && v <= 2047)
          push_beat(32'(((u & 'hFFF) << 20) | (d << 7) | 'h13), 1'b1, 1'b0);
        else if (lo_s == 0)
          push_beat(32'((hi << 12) | (d << 7) | 'h37), 1'b1, 1'b0);
        else begin
          push_beat(32'((hi << 12) | (d << 7) | 'h37), 1'b0, 1'b0);
          push_beat(32'(((u & 'hFFF) << 20) | (d << 15) | (d << 7) | 'h13), 1'b1, 1'b0);
        end
      end
    endcase
  endfunction

  task automatic drive_random_req();
    int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                    1048574, -1048576, 1048576, -1048578, 4095, 3};
    int sel;
    logic [31:0] imm;
    sel = int'($urandom_range(0, 9));
    if (sel <= 3)      imm = 32'(int'($urandom_range(0, 4095)) - 2048);
    else if (sel == 4) imm = 32'(bnd[$urandom_range(0, 13)]);
    else if (sel <= 6) imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
    else if (sel == 7) imm = $urandom & 32'hFFFFF000;
    else               imm = $urandom;
    if (sel >= 5 && $urandom_range(0, 1) == 1) imm = imm & 32'hFFFFFFFE;
    req_kind   = enc_kind_t'(3'($urandom_range(0, 4)));
    req_opcode = 7'($urandom);
    req_funct3 = 3'($urandom);
    req_rd     = 5'($urandom);
    req_rs1    = 5'($urandom);
    req_rs2    = 5'($urandom);
    req_imm    = imm;
    req_valid  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_last !== 1'b0 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b instr=%h last=%b err=%b, want 0 0 0 0",
               out_valid, out_instr, out_last, out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b, want 1", req_ready);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    enc_kind_t   k[7]   = '{ENC_I, ENC_B, ENC_LI, ENC_LI, ENC_B, ENC_J, ENC_S};
    logic [6:0]  op[7]  = '{op_imm, op_br, 7'd0, 7'd0, op_br, op_jump, op_store};
    logic [2:0]  f3[7]  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
    logic [4:0]  rd[7]  = '{5'd5, 5'd0, 5'd10, 5'd10, 5'd0, 5'd1, 5'd0};
    logic [4:0]  r1[7]  = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2};
    logic [4:0]  r2[7]  = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd1};
    logic [31:0] im[7]  = '{32'hFFFFFFFF, 32'd8, 32'h12345FFF, 32'h00001000, 32'd3, 32'd2048, 32'hFFFFFFFC};
    int          nb[7]  = '{1, 1, 2, 1, 1, 1, 1};
    logic [31:0] w0[7]  = '{32'hFFF00293, 32'h00208463, 32'h12346537, 32'h00001537, 32'h0,
                            32'h001000EF, 32'hFE112E23};
    logic        l0[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        e0[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] w1[7]  = '{32'h0, 32'h0, 32'hFFF50513, 32'h0, 32'h0, 32'h0, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_kind = k[i]; req_opcode = op[i]; req_funct3 = f3[i];
      req_rd = rd[i]; req_rs1 = r1[i]; req_rs2 = r2[i]; req_imm = im[i];
      req_valid = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL dir%0d_ready: got %b, want 1", i, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_instr !== w0[i] || out_last !== l0[i] || out_err !== e0[i]) begin
        tests_failed++;
        $display("FAIL dir%0d_word0: got v=%b %h last=%b err=%b, want v=1 %h last=%b err=%b",
                 i, out_valid, out_instr, out_last, out_err, w0[i], l0[i], e0[i]);
      end
      if (nb[i] == 2) begin
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_instr !== w1[i] || out_last !== 1'b1 || out_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL dir%0d_word1: got v=%b %h last=%b err=%b, want v=1 %h last=1 err=0",
                   i, out_valid, out_instr, out_last, out_err, w1[i]);
        end
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL dir%0d_idle: got out_valid=%b, want 0", i, out_valid);
      end
      $display("[TB] directed %0d kind=%0d imm=%h beats=%0d", i, k[i], im[i], nb[i]);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        req_kind = ENC_I; req_opcode = op_imm; req_funct3 = 3'($urandom);
        req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'd0;
        req_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        tests_run++;
        b = exp_q.pop_front();
        if (out_valid !== 1'b1 || out_instr !== b.instr || out_last !== 1'b1 || out_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b%0d_word: got v=%b %h last=%b err=%b, want v=1 %h last=1 err=0",
                   i, out_valid, out_instr, out_last, out_err, b.instr);
        end
        $display("[TB] back_to_back beat %0d instr=%h", i - 1, out_instr);
      end
      if (i < 8) begin
        tests_run++;
        if (req_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b%0d_ready: got %b, want 1", i, req_ready);
        end
        model(req_kind, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm);
      end
    end
  endtask

  task automatic test_random(input int n_req, input int ready_pct);
    int          sent = 0;
    int          cycles = 0;
    logic        acc = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr = '0;
    logic        prev_last = 1'b0, prev_err = 1'b0;
    beat_t       b;
    exp_q.delete();
    req_valid = 1'b0;
    while ((sent < n_req || exp_q.size() != 0) && cycles < 6000) begin
      @(negedge clk);
      cycles++;
      if (acc) begin
        req_valid = 1'b0;
        acc = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (!req_valid && sent < n_req && $urandom_range(0, 3) != 0) drive_random_req();
      #1;
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_instr !== prev_instr || out_last !== prev_last || out_err !== prev_err) begin
          tests_failed++;
          $display("FAIL rand_hold: got v=%b %h last=%b err=%b, want v=1 %h last=%b err=%b",
                   out_valid, out_instr, out_last, out_err, prev_instr, prev_last, prev_err);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_extra_beat: got %h, want no beat", out_instr);
        end else begin
          b = exp_q.pop_front();
          if (out_instr !== b.instr || out_last !== b.last || out_err !== b.err) begin
            tests_failed++;
            $display("FAIL rand_beat: got %h last=%b err=%b, want %h last=%b err=%b",
                     out_instr, out_last, out_err, b.instr, b.last, b.err);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_last  = out_last;
      prev_err   = out_err;
      if (req_valid && req_ready) begin
        model(req_kind, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm);
        $display("[TB] rand req %0d kind=%0d imm=%h", sent, req_kind, req_imm);
        sent++;
        acc = 1'b1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (sent != n_req || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_timeout: got sent=%0d pending=%0d, want sent=%0d pending=0",
               sent, exp_q.size(), n_req);
    end
  endtask

  task automatic test_backpressure_reset();
    out_ready = 1'b0;
    @(negedge clk);
    req_kind = ENC_LI; req_opcode = 7'd0; req_funct3 = 3'd0;
    req_rd = 5'd10; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'h12345FFF;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_instr !== 32'h12346537 || out_last !== 1'b0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: got v=%b %h last=%b ready=%b, want v=1 12346537 last=0 ready=0",
                 i, out_valid, out_instr, out_last, req_ready);
      end
      $display("[TB] backpressure cycle %0d instr=%h", i, out_instr);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_instr !== 32'h12346537 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got %h ready=%b, want 12346537 ready=0", out_instr, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_reset_valid: got %b, want 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_no_second%0d: got v=%b instr=%h ready=%b, want v=0 ready=1",
                 i, out_valid, out_instr, req_ready);
      end
    end
    $display("[TB] reset during LI checked");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(150, 70);
    test_random(150, 100);
    test_random(100, 30);
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter WIDTH, default 32, instruction and immediate width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_kind  input  enc_kind_t  one of ENC_I, ENC_S, ENC_B, ENC_J, ENC_LI.
REQ-007 req_opcode  input  7  opcode; ignored for ENC_LI.
REQ-008 req_funct3  input  3  funct3; ignored for ENC_J and ENC_LI.
REQ-009 req_rd / req_rs1 / req_rs2  input  5 each  register indices; unused fields ignored per format.
REQ-010 req_imm  input  WIDTH  signed byte-offset or value immediate.
REQ-011 out_valid  output  1  out_instr valid.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 out_instr  output  WIDTH  encoded instruction word.
REQ-014 out_last  output  1  final word of current request.
REQ-015 out_err  output  1  immediate unencodable; qualifies out_valid.

Function
REQ-016 Range rules: ENC_I and ENC_S require req_imm in [-2048, 2047]; ENC_B requires req_imm in [-4096, 4094] with bit0 = 0; ENC_J requires req_imm in [-1048576, 1048574] with bit0 = 0; ENC_LI accepts any value.
REQ-017 Packing: I = imm[11:0], rs1, funct3, rd, opcode; S = imm[11:5], rs2, rs1, funct3, imm[4:0], opcode; B = imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode; J = imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
REQ-018 ENC_LI expansion, with lo = imm[11:0] and hi = imm[31:12] + imm[11] (mod 2^20):
  - imm in [-2048, 2047]: one ADDI rd, x0, lo.
  - else lo == 0: one LUI rd, hi.
  - else: LUI rd, hi, then ADDI rd, rd, lo.
REQ-019 ADDI uses op_imm with funct3 000; LUI uses op_lui.
REQ-020 Range violation: one beat with out_instr = 0, out_err = 1, out_last = 1.
REQ-021 FSM states:
  - IDLE -> EMIT1 on accept.
  - EMIT1 -> IDLE on handshake when out_last = 1.
  - EMIT1 -> EMIT2 on handshake when out_last = 0.
  - EMIT2 -> IDLE on handshake.
REQ-022 Output registered: request accepted in cycle N presents its first word in cycle N+1.
REQ-023 out_instr, out_last and out_err are held stable while out_valid && !out_ready.
REQ-024 req_ready = (state == IDLE) || (out_valid && out_ready && out_last), allowing back-to-back single-beat requests at one per cycle.
REQ-025 A request accepted in the same cycle as a final-beat handshake loads directly into EMIT1.
REQ-026 The second LI word is presented the cycle after the first word's handshake.
REQ-027 out_err = 0 on every word of a valid encoding.
REQ-028 out_last = 0 only on the LUI of a two-word LI expansion.

Reset
REQ-029 While rst_n = 0 at a clk edge:
  - state -> IDLE;
  - out_valid, out_last, out_err = 0;
  - out_instr = 0;
  - the pending LI second word is discarded.
REQ-030 req_ready is 1 the first cycle after reset deassertion.

Structure
REQ-031 enc_kind_t and op_lui (7'b0110111) live in riscv_types, alongside the existing op_imm, op_load, op_store, op_br and op_jump.
REQ-032 Format packing is a combinational sub-module, instr_pack (kind, opcode, funct3, rd, rs1, rs2, imm -> word); the FSM and registers live in instr_encoder.

Verification
REQ-033 ENC_I, opcode op_imm, funct3 0, rd 5, rs1 0, imm -1 -> one beat 0xFFF00293, out_last = 1, out_err = 0.
REQ-034 ENC_B, opcode op_br, funct3 0, rs1 1, rs2 2, imm 8 -> 0x00208463.
REQ-035 ENC_LI, rd 10, imm 0x12345FFF -> 0x12346537 with out_last = 0, then 0xFFF50513 with out_last = 1.
REQ-036 ENC_LI, rd 10, imm 0x00001000 -> single beat 0x00001537.
REQ-037 ENC_B, imm 3 -> single beat, out_instr 0, out_err = 1.
REQ-038 Backpressure and reset during LI 0x12345FFF:
  - out_ready low for 3 cycles -> first word stable and req_ready = 0 throughout;
  - rst_n low after the first-word handshake -> out_valid = 0 next cycle and the second word is never emitted.
